// File: rtl/alu_seq_unit.sv
// ============================================================================
// Module   : alu_seq_unit
// Brief    : Valid/ready execution unit: single-cycle logic/arith/compare ops,
//            bit-serial shifts (one bit per cycle).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   acc_q,     acc_d;
    logic [SHAMT_W-1:0] cnt_q,     cnt_d;
    logic [3:0]         op_q,      op_d;
    logic [WIDTH-1:0]   result_q,  result_d;
    logic               zero_q,    zero_d;
    logic               illegal_q, illegal_d;

    logic [WIDTH-1:0]   w_shifted;
    logic [SHAMT_W-1:0] w_shamt;

    assign w_shamt = src_b[SHAMT_W-1:0];

    // One-bit step of the serial shifter; op_q only ever holds a shift code here.
    always_comb begin
        w_shifted = acc_q;
        case (op_q)
            OP_SLL:  w_shifted = {acc_q[WIDTH-2:0], 1'b0};
            OP_SRL:  w_shifted = {1'b0, acc_q[WIDTH-1:1]};
            default: w_shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                    case (alu_control)
                        OP_ADD:  result_d = src_a + src_b;
                        OP_SUB:  result_d = src_a - src_b;
                        OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
                        OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
                        OP_XOR:  result_d = src_a ^ src_b;
                        OP_AND:  result_d = src_a & src_b;
                        OP_OR:   result_d = src_a | src_b;
                        OP_SLL, OP_SRL, OP_SRA: begin
                            acc_d = src_a;
                            cnt_d = w_shamt;
                            op_d  = alu_control;
                            if (w_shamt == '0) begin
                                result_d = src_a;
                            end else begin
                                state_d = ST_SHIFT;
                            end
                        end
                        default: begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                        end
                    endcase
                    if (state_d == ST_DONE) begin
                        zero_d = (result_d == '0);
                    end
                end
            end

            ST_SHIFT: begin
                acc_d = w_shifted;
                cnt_d = cnt_q - SHAMT_W'(1);
                // The last step lands directly in result so DONE follows n SHIFT cycles.
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = w_shifted;
                    zero_d   = (w_shifted == '0);
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

`default_nettype wire
